// File: rtl/fetch_unit_if.sv
// Fetch-side bus of fetch_unit: control from decode, LUT write port, ROM port and status.
// The master modport is the fetch unit; the slave modport is the surrounding core.
interface fetch_unit_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int LUT_D   = 16
);
  localparam int IDX_W = (LUT_D > 1) ? $clog2(LUT_D) : 1;

  logic               stall_i;
  logic               branch_i;
  logic [IDX_W-1:0]   branch_idx_i;
  logic               lut_we_i;
  logic [IDX_W-1:0]   lut_waddr_i;
  logic [PC_W-1:0]    lut_wdata_i;
  logic [PC_W-1:0]    pc_o;
  logic [INSTR_W-1:0] instr_i;
  logic [INSTR_W-1:0] instr_o;
  logic               instr_valid_o;
  logic               done_o;
  logic [15:0]        cycle_count_o;

  modport master (
    input  stall_i, branch_i, branch_idx_i,
    input  lut_we_i, lut_waddr_i, lut_wdata_i,
    input  instr_i,
    output pc_o, instr_o, instr_valid_o, done_o, cycle_count_o
  );

  modport slave (
    output stall_i, branch_i, branch_idx_i,
    output lut_we_i, lut_waddr_i, lut_wdata_i,
    output instr_i,
    input  pc_o, instr_o, instr_valid_o, done_o, cycle_count_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage driving a 1-cycle-latency ROM: sequential fetch, LUT-based
// branch redirect with squash of the in-flight word, stall skid, sticky halt detection.
module fetch_unit #(
  parameter int                 PC_W    = 10,
  parameter int                 INSTR_W = 9,
  parameter int                 LUT_D   = 16,
  parameter logic [INSTR_W-1:0] HALT_OP = '1
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int IDX_W = (LUT_D > 1) ? $clog2(LUT_D) : 1;

  typedef enum logic {
    RUN,
    HALT
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic               valid_q, valid_d;
  logic               squash_q, squash_d;
  logic               live_q, live_d;
  logic               held_q, held_d;
  logic               done_q, done_d;
  logic [15:0]        count_q, count_d;
  logic [PC_W-1:0]    lut_q [LUT_D];

  logic               halt_hit;
  logic               take_branch;
  logic [INSTR_W-1:0] fetched;
  logic [PC_W-1:0]    target;

  assign halt_hit    = valid_q && (instr_q == HALT_OP);
  assign take_branch = bus.branch_i && valid_q;
  assign target      = lut_q[bus.branch_idx_i];

  // While stalled the ROM keeps re-reading the held pc, so the word that was in
  // flight when the stall began lives in the skid register until fetch resumes.
  assign fetched = held_q ? skid_q : bus.instr_i;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    skid_d   = skid_q;
    valid_d  = valid_q;
    squash_d = squash_q;
    live_d   = live_q;
    held_d   = held_q;
    done_d   = done_q;
    count_d  = count_q;

    unique case (state_q)
      RUN: begin
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;

        if (halt_hit) begin
          state_d = HALT;
          done_d  = 1'b1;
          valid_d = 1'b0;
        end else if (take_branch) begin
          // Redirect now; the word already in flight from the old path is killed next cycle.
          pc_d     = target;
          valid_d  = 1'b0;
          squash_d = 1'b1;
          held_d   = 1'b0;
        end else if (bus.stall_i) begin
          if (!held_q) begin
            skid_d = bus.instr_i;
            held_d = 1'b1;
          end
        end else begin
          pc_d     = pc_q + 1'b1;
          instr_d  = fetched;
          // The ROM word seen in the first cycle after reset was not addressed by a fetch.
          valid_d  = live_q && !squash_q;
          squash_d = 1'b0;
          live_d   = 1'b1;
          held_d   = 1'b0;
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      instr_q  <= '0;
      skid_q   <= '0;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
      live_q   <= 1'b0;
      held_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      skid_q   <= skid_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
      live_q   <= live_d;
      held_q   <= held_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the LUT must come out of reset all-zero, so it is a register array with an
  // explicit clear rather than an inferred RAM; reset also blocks a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_D; i++) lut_q[i] <= '0;
    end else if (bus.lut_we_i) begin
      lut_q[bus.lut_waddr_i] <= bus.lut_wdata_i;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.instr_o       = instr_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.done_o        = done_q;
  assign bus.cycle_count_o = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: synchronous ROM model, scoreboard of expected
// instruction words consumed whenever a valid word is accepted (valid and not stalled).
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int LUT_D   = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_D(LUT_D)) bus ();

  fetch_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_D(LUT_D), .HALT_OP(9'h1FF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] rom [1024];
  always @(posedge clk) bus.instr_i <= rom[bus.pc_o];

  logic [8:0] sb [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] rom_word(input int a);
    logic [8:0] w;
    w = a[8:0];
    if (w == 9'h1FF) w = 9'h0AA;
    return w;
  endfunction

  task automatic load_rom(input bit with_halt);
    for (int i = 0; i < 1024; i++) rom[i] = rom_word(i);
    if (with_halt) begin
      for (int k = 0; k < 5; k++) rom[k] = 9'(k);
      rom[5] = 9'h1FF;
    end
  endtask

  task automatic idle();
    bus.stall_i      = 1'b0;
    bus.branch_i     = 1'b0;
    bus.branch_idx_i = '0;
    bus.lut_we_i     = 1'b0;
    bus.lut_waddr_i  = '0;
    bus.lut_wdata_i  = '0;
  endtask

  // Consume the presented word if downstream accepts it, then advance one edge.
  task automatic step();
    if (!reset && bus.instr_valid_o && !bus.stall_i) begin
      if (sb.size() == 0) check("sb_extra_word", 32'(sb.size()), 32'd1);
      else                check("sb_instr", 32'(bus.instr_o), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},    32'(bus.pc_o), 32'd0);
    check({tag, "_instr"}, 32'(bus.instr_o), 32'd0);
    check({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd0);
    check({tag, "_done"},  32'(bus.done_o), 32'd0);
    check({tag, "_count"}, 32'(bus.cycle_count_o), 32'd0);
  endtask

  task automatic drain(input string tag);
    check(tag, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    bus.instr_i = '0;

    // ---- T1: straight-line program ending in halt ----
    load_rom(1'b1);
    hold_reset(3);
    check_reset_state("rst");
    reset = 1'b0;
    foreach (rom[k]) if (k <= 5) sb.push_back(rom[k]);
    step();
    check("first_edge_valid", 32'(bus.instr_valid_o), 32'd0);
    step();
    check("second_edge_valid", 32'(bus.instr_valid_o), 32'd1);
    check("second_edge_instr", 32'(bus.instr_o), 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("halt_word", 32'(bus.instr_o), 32'h1FF);
    step();
    check("halt_done", 32'(bus.done_o), 32'd1);
    check("halt_valid", 32'(bus.instr_valid_o), 32'd0);
    check("halt_pc", 32'(bus.pc_o), 32'd7);
    check("halt_count", 32'(bus.cycle_count_o), 32'd8);
    drain("t1_drain");
    bus.branch_i = 1'b1; bus.stall_i = 1'b1; bus.branch_idx_i = 4'd2;
    bus.lut_we_i = 1'b1; bus.lut_waddr_i = 4'd2; bus.lut_wdata_i = 10'h155;
    for (int i = 0; i < 3; i++) step();
    check("halt_frozen_pc", 32'(bus.pc_o), 32'd7);
    check("halt_frozen_count", 32'(bus.cycle_count_o), 32'd8);
    check("halt_sticky_done", 32'(bus.done_o), 32'd1);
    check("halt_instr", 32'(bus.instr_o), 32'h1FF);

    // ---- T4: reset during HALT overrides a LUT write; program restarts ----
    idle();
    bus.branch_i = 1'b1;
    bus.lut_we_i = 1'b1; bus.lut_waddr_i = 4'd3; bus.lut_wdata_i = 10'h3C0;
    hold_reset(1);
    check_reset_state("rst_in_halt");
    idle();
    reset = 1'b0;
    sb.push_back(9'd0);
    step();
    step();
    check("restart_valid", 32'(bus.instr_valid_o), 32'd1);
    check("restart_instr", 32'(bus.instr_o), 32'd0);
    bus.branch_i = 1'b1; bus.branch_idx_i = 4'd3;
    step();
    check("lut_write_blocked_by_reset", 32'(bus.pc_o), 32'd0);
    idle();
    sb.push_back(rom[0]);
    step();
    step();
    step();
    drain("t4_drain");

    // ---- T2: branch through LUT, then branch with stall in the same cycle ----
    load_rom(1'b0);
    hold_reset(2);
    reset = 1'b0;
    bus.lut_we_i = 1'b1; bus.lut_waddr_i = 4'd3; bus.lut_wdata_i = 10'h040;
    sb.push_back(9'd0); sb.push_back(9'd1); sb.push_back(9'd2);
    step();
    idle();
    step(); step(); step();
    check("pre_branch_instr", 32'(bus.instr_o), 32'd2);
    bus.branch_i = 1'b1; bus.branch_idx_i = 4'd3;
    step();
    check("branch_pc", 32'(bus.pc_o), 32'h040);
    check("squash_valid_1", 32'(bus.instr_valid_o), 32'd0);
    idle();
    sb.push_back(rom_word(10'h040));
    step();
    check("squash_valid_2", 32'(bus.instr_valid_o), 32'd0);
    step();
    check("post_branch_valid", 32'(bus.instr_valid_o), 32'd1);
    check("post_branch_instr", 32'(bus.instr_o), 32'(rom_word(10'h040)));
    bus.lut_we_i = 1'b1; bus.lut_waddr_i = 4'd7; bus.lut_wdata_i = 10'h100;
    step();
    idle();
    bus.branch_i = 1'b1; bus.branch_idx_i = 4'd7; bus.stall_i = 1'b1;
    step();
    check("branch_beats_stall_pc", 32'(bus.pc_o), 32'h100);
    check("branch_beats_stall_valid", 32'(bus.instr_valid_o), 32'd0);
    idle();
    sb.push_back(rom_word(10'h100)); sb.push_back(rom_word(10'h101));
    step(); step(); step(); step();
    drain("t2_drain");

    // ---- T3: three-cycle stall with instr_o == 2 ----
    hold_reset(2);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) sb.push_back(rom_word(k));
    for (int i = 0; i < 4; i++) step();
    check("stall_entry_instr", 32'(bus.instr_o), 32'd2);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr_hold", 32'(bus.instr_o), 32'd2);
      check("stall_pc_hold", 32'(bus.pc_o), 32'd4);
    end
    check("stall_count", 32'(bus.cycle_count_o), 32'd7);
    bus.stall_i = 1'b0;
    step();
    check("resume_instr", 32'(bus.instr_o), 32'd3);
    check("resume_pc", 32'(bus.pc_o), 32'd5);
    step(); step(); step();
    drain("t3_drain");

    // ---- T5: pc wrap, ignored branch, same-cycle LUT write/read ----
    hold_reset(2);
    reset = 1'b0;
    bus.lut_we_i = 1'b1; bus.lut_waddr_i = 4'd1; bus.lut_wdata_i = 10'h010;
    step();
    bus.lut_waddr_i = 4'd2; bus.lut_wdata_i = 10'h3FE;
    step();
    idle();
    sb.push_back(9'd0);
    bus.branch_i = 1'b1; bus.branch_idx_i = 4'd2;
    step();
    check("wrap_branch_pc", 32'(bus.pc_o), 32'h3FE);
    bus.branch_idx_i = 4'd1;
    step();
    check("ignored_branch_pc", 32'(bus.pc_o), 32'h3FF);
    idle();
    step();
    check("wrap_pc", 32'(bus.pc_o), 32'd0);
    check("wrap_instr", 32'(bus.instr_o), 32'(rom_word(10'h3FE)));
    sb.push_back(rom_word(10'h3FE)); sb.push_back(rom_word(10'h3FF)); sb.push_back(rom_word(0));
    step(); step();
    bus.lut_we_i = 1'b1; bus.lut_waddr_i = 4'd1; bus.lut_wdata_i = 10'h080;
    bus.branch_i = 1'b1; bus.branch_idx_i = 4'd1;
    step();
    check("lut_old_contents", 32'(bus.pc_o), 32'h010);
    idle();
    sb.push_back(rom_word(10'h010));
    step(); step();
    bus.branch_i = 1'b1; bus.branch_idx_i = 4'd1;
    step();
    check("lut_new_contents", 32'(bus.pc_o), 32'h080);
    idle();
    sb.push_back(rom_word(10'h080));
    step(); step(); step();
    drain("t5_drain");

    // ---- T6: cycle counter saturation under a long stall ----
    hold_reset(2);
    reset = 1'b0;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check("count_saturated", 32'(bus.cycle_count_o), 32'hFFFF);
    check("long_stall_pc", 32'(bus.pc_o), 32'd0);
    bus.stall_i = 1'b0;
    step();
    step();
    check("count_stays_saturated", 32'(bus.cycle_count_o), 32'hFFFF);
    check("after_stall_valid", 32'(bus.instr_valid_o), 32'd1);
    check("after_stall_instr", 32'(bus.instr_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 10: program counter width in bits.
REQ-002 Parameter INSTR_W, default 9: instruction width in bits.
REQ-003 Parameter LUT_D, default 16: branch-target lookup table depth.
REQ-004 Parameter HALT_OP, default all ones (9'h1FF): halt instruction encoding.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall_i  input  1  downstream not ready; freeze fetch pipeline.
REQ-008 branch_i  input  1  taken branch from decode of current instr_o.
REQ-009 branch_idx_i  input  log2(LUT_D)  LUT index selecting branch target.
REQ-010 lut_we_i  input  1  LUT write enable.
REQ-011 lut_waddr_i  input  log2(LUT_D)  LUT write index.
REQ-012 lut_wdata_i  input  PC_W  LUT write data (absolute target address).
REQ-013 pc_o  output  PC_W  address to synchronous instruction ROM (1-cycle read latency).
REQ-014 instr_i  input  INSTR_W  ROM data for address presented previous cycle.
REQ-015 instr_o  output  INSTR_W  registered instruction to decode.
REQ-016 instr_valid_o  output  1  instr_o holds a live instruction.
REQ-017 done_o  output  1  sticky halt indication to the top level.
REQ-018 cycle_count_o  output  16  cycles spent in RUN state.

Function
REQ-019 States: RUN and HALT only; reset forces RUN.
REQ-020 RUN, no stall, no branch: pc_o <= pc_o + 1 each cycle; instr_o <= instr_i; instr_valid_o <= 1 unless a squash is pending.
REQ-021 Fetch latency: address A on pc_o at cycle n -> ROM word on instr_i at n+1 -> instr_o/instr_valid_o at n+2.
REQ-022 pc_o increment wraps modulo 2^PC_W (max -> 0) with no error flag.
REQ-023 stall_i=1 in RUN: pc_o, instr_o, instr_valid_o, pending-squash flag all hold; cycle_count_o still increments.
REQ-024 branch_i=1 with instr_valid_o=1 in RUN: pc_o <= lut[branch_idx_i]; instr_valid_o <= 0 next cycle; pending squash kills the already in-flight word so first valid post-branch instruction appears exactly 2 cycles after the branch cycle.
REQ-025 branch_i with instr_valid_o=0 ignored.
REQ-026 branch_i and stall_i same cycle: branch wins; redirect and squash proceed.
REQ-027 LUT write: lut[lut_waddr_i] <= lut_wdata_i on lut_we_i, any state; branch reading same index same cycle uses old contents.
REQ-028 Halt detect: instr_valid_o=1 and instr_o==HALT_OP -> next cycle state HALT, done_o=1, instr_valid_o=0.
REQ-029 Halt has priority over branch_i and stall_i in the detect cycle.
REQ-030 HALT: pc_o, instr_o, cycle_count_o frozen; done_o stays 1 until reset; branch_i, stall_i ignored; LUT writes still accepted.
REQ-031 cycle_count_o increments once per RUN cycle, saturates at 16'hFFFF.

Reset
REQ-032 On reset: pc_o=0, instr_o=0, instr_valid_o=0, done_o=0, cycle_count_o=0, squash flag cleared, all LUT entries 0, state RUN.
REQ-033 Reset asserted mid-operation (including HALT) takes effect next edge and overrides all other inputs, including lut_we_i.
REQ-034 First valid instruction after reset release: word at address 0, instr_valid_o=1 on 2nd edge after release.

Verification
REQ-035 ROM addr k holds k (k<5), addr 5 holds 9'h1FF; release reset -> instr_o 0,1,2,3,4 on consecutive cycles, then done_o=1 one cycle after instr_o=9'h1FF, pc_o frozen thereafter.
REQ-036 Write lut[3]=10'h040; branch_i=1, branch_idx_i=3 when instr_o=2 -> pc_o=10'h040 next cycle, instr_valid_o=0 two cycles, then instr_o=ROM[0x040].
REQ-037 stall_i=1 for 3 cycles with instr_o=2 -> instr_o, pc_o unchanged 3 cycles, cycle_count_o +3; resume yields 3 next without loss or duplication.
REQ-038 pc_o=10'h3FF, no branch -> pc_o=0 next cycle; branch+stall same cycle -> redirect taken.
REQ-039 Same-cycle lut write idx 1 (10'h080) and branch idx 1 (old 10'h010) -> pc_o=10'h010; later branch idx 1 -> 10'h080.
REQ-040 Reset asserted while done_o=1 -> all outputs per REQ-032 next edge; program restarts from address 0.
